// File: rtl/ex_core_alu_pkg.sv
// Shared definitions for the ex_core ALU, its request sequencer and their benches.
// Opcode encoding and the sequencer state enum live here so every user agrees.
package ex_core_alu_pkg;

    localparam int ALU_OP_W      = 4;
    localparam int LAST_LEGAL_OP = 9;

    typedef enum logic [ALU_OP_W-1:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        AND  = 4'd2,
        OR   = 4'd3,
        XOR  = 4'd4,
        SLL  = 4'd5,
        SRL  = 4'd6,
        SRA  = 4'd7,
        SLT  = 4'd8,
        SLTU = 4'd9
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } ctrl_state_t;

    function automatic logic op_is_illegal(input logic [ALU_OP_W-1:0] op);
        return op > ALU_OP_W'(LAST_LEGAL_OP);
    endfunction

endpackage

// File: rtl/ex_core_alu_req_fifo.sv
// Synchronous request FIFO with head-of-queue read data and an occupancy count.
// Push while full and pop while empty are ignored; pointers wrap modulo DEPTH.
module ex_core_alu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   Clk,
    input  logic                   Rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset: entries are only visible between the pointers.
    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ex_core_alu_ctrl.sv
// Initiator-side sequencer for the combinational ex_core ALU: queues tagged requests,
// runs them one at a time through registered ALU inputs and returns in-order responses.
module ex_core_alu_ctrl
    import ex_core_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_op1,
    input  logic [31:0]         req_op2,
    input  logic [ALU_OP_W-1:0] req_op,
    input  logic [TAG_W-1:0]    req_tag,
    output logic [31:0]         alu_operand1,
    output logic [31:0]         alu_operand2,
    output logic [ALU_OP_W-1:0] alu_op,
    input  logic [31:0]         alu_result,
    input  logic                alu_zero,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_result,
    output logic                rsp_zero,
    output logic                rsp_err,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic                busy,
    output logic [CNT_W-1:0]    done_cnt
);

    localparam int REQ_W  = TAG_W + ALU_OP_W + 64;
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    ctrl_state_t          state;
    logic [REQ_W-1:0]     fifo_wdata;
    logic [REQ_W-1:0]     fifo_rdata;
    logic [FCNT_W-1:0]    fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic [TAG_W-1:0]     head_tag;
    logic [ALU_OP_W-1:0]  head_op;
    logic [31:0]          head_op1;
    logic [31:0]          head_op2;
    logic                 head_illegal;
    logic                 err_r;
    logic [TAG_W-1:0]     tag_r;

    // Ready depends only on the registered occupancy, never on the response side.
    assign req_ready  = (fifo_count != FCNT_W'(DEPTH));
    assign fifo_wdata = {req_tag, req_op, req_op1, req_op2};
    assign fifo_pop   = (state == IDLE) && !fifo_empty;
    assign {head_tag, head_op, head_op1, head_op2} = fifo_rdata;
    assign head_illegal = op_is_illegal(head_op);
    assign busy = (state != IDLE) || (fifo_count != '0);

    ex_core_alu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_req_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (req_valid && req_ready),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            alu_operand1 <= '0;
            alu_operand2 <= '0;
            alu_op       <= '0;
            err_r        <= 1'b0;
            tag_r        <= '0;
            rsp_valid    <= 1'b0;
            rsp_result   <= '0;
            rsp_zero     <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_tag      <= '0;
            done_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_operand1 <= head_op1;
                        alu_operand2 <= head_op2;
                        // An illegal opcode still drives a defined op into the ALU.
                        alu_op       <= head_illegal ? ADD : head_op;
                        err_r        <= head_illegal;
                        tag_r        <= head_tag;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= err_r ? 32'd0 : alu_result;
                    rsp_zero   <= err_r ? 1'b0 : alu_zero;
                    rsp_err    <= err_r;
                    rsp_tag    <= tag_r;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        done_cnt  <= done_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
